// File: rtl/execute_muldiv_if.sv
// Operand/result bundle between the execute stage and the iterative RV32M mul/div unit.
// The master drives operands and control; the slave (mul/div unit) drives busy/done/result.
interface execute_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            E_md_valid_i;
    logic [2:0]      E_md_op_i;
    logic [XLEN-1:0] E_rs1_data_i;
    logic [XLEN-1:0] E_rs2_data_i;
    logic            E_md_kill_i;
    logic            E_md_busy_o;
    logic            E_md_done_o;
    logic [XLEN-1:0] E_md_result_o;

    modport master (
        output E_md_valid_i, E_md_op_i, E_rs1_data_i, E_rs2_data_i, E_md_kill_i,
        input  E_md_busy_o, E_md_done_o, E_md_result_o
    );

    modport slave (
        input  E_md_valid_i, E_md_op_i, E_rs1_data_i, E_rs2_data_i, E_md_kill_i,
        output E_md_busy_o, E_md_done_o, E_md_result_o
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, XLEN steps.
// Optional macro DIV_EARLY_OUT_EN: divides with |rs1| < |rs2| finish in one cycle.
module execute_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst,
    execute_muldiv_if.slave   bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [2:0]      r_op, w_op_nxt;
    logic            r_neg, w_neg_nxt;
    logic            r_neg_rem, w_neg_rem_nxt;
    logic [XLEN-1:0] r_b, w_b_nxt;
    logic [PW-1:0]   r_acc, w_acc_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_done, w_done_nxt;

    logic [2:0]      w_op;
    logic [XLEN-1:0] w_rs1, w_rs2, w_mag_a, w_mag_b, w_special_res;
    logic            w_start, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_is_div, w_div0, w_ovf, w_early, w_special;

    assign w_op  = bus.E_md_op_i;
    assign w_rs1 = bus.E_rs1_data_i;
    assign w_rs2 = bus.E_rs2_data_i;

    assign w_start    = (r_state == S_IDLE) && bus.E_md_valid_i && !bus.E_md_kill_i;
    assign w_a_signed = (w_op != 3'd3) && (w_op != 3'd5) && (w_op != 3'd7);
    assign w_b_signed = (w_op == 3'd0) || (w_op == 3'd1) || (w_op == 3'd4) || (w_op == 3'd6);
    assign w_sa       = w_a_signed && w_rs1[XLEN-1];
    assign w_sb       = w_b_signed && w_rs2[XLEN-1];
    assign w_mag_a    = w_sa ? (XLEN'(0) - w_rs1) : w_rs1;
    assign w_mag_b    = w_sb ? (XLEN'(0) - w_rs2) : w_rs2;

    // Divides that resolve without iterating
    assign w_is_div = w_op[2];
    assign w_div0   = w_is_div && (w_rs2 == '0);
    assign w_ovf    = w_is_div && !w_op[0] && (w_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_rs2 == '1);
`ifdef DIV_EARLY_OUT_EN
    assign w_early  = w_is_div && (w_rs2 != '0) && (w_mag_a < w_mag_b);
`else
    assign w_early  = 1'b0;
`endif
    assign w_special = w_div0 || w_ovf || w_early;

    always_comb begin
        w_special_res = '0;
        if (w_div0)      w_special_res = w_op[1] ? w_rs1 : '1;
        else if (w_ovf)  w_special_res = w_op[1] ? '0 : w_rs1;
        else if (w_early) w_special_res = w_op[1] ? w_rs1 : '0;
    end

    // One iteration: hi half is product-high / partial remainder, lo half is multiplier / quotient
    logic [XLEN:0]   w_madd, w_dsh, w_ddiff;
    logic            w_dge;
    logic [PW-1:0]   w_mstep, w_dstep, w_step, w_prod_fix;
    logic [XLEN-1:0] w_q, w_r, w_mul_res, w_div_res, w_final;

    assign w_madd  = {1'b0, r_acc[PW-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mstep = {w_madd, r_acc[XLEN-1:1]};
    assign w_dsh   = {r_acc[PW-1:XLEN], r_acc[XLEN-1]};
    assign w_ddiff = w_dsh - {1'b0, r_b};
    assign w_dge   = !w_ddiff[XLEN];
    assign w_dstep = {(w_dge ? w_ddiff[XLEN-1:0] : w_dsh[XLEN-1:0]), r_acc[XLEN-2:0], w_dge};
    assign w_step  = r_op[2] ? w_dstep : w_mstep;

    assign w_prod_fix = r_neg ? (PW'(0) - w_step) : w_step;
    assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[PW-1:XLEN];
    assign w_q        = w_step[XLEN-1:0];
    assign w_r        = w_step[PW-1:XLEN];
    assign w_div_res  = r_op[1] ? (r_neg_rem ? (XLEN'(0) - w_r) : w_r)
                                : (r_neg     ? (XLEN'(0) - w_q) : w_q);
    assign w_final    = r_op[2] ? w_div_res : w_mul_res;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_op_nxt      = r_op;
        w_neg_nxt     = r_neg;
        w_neg_rem_nxt = r_neg_rem;
        w_b_nxt       = r_b;
        w_acc_nxt     = r_acc;
        w_result_nxt  = r_result;
        w_done_nxt    = 1'b0;
        if (bus.E_md_kill_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.E_md_valid_i) begin
                        if (w_special) begin
                            w_result_nxt = w_special_res;
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_DONE;
                        end else begin
                            w_op_nxt      = w_op;
                            w_neg_nxt     = w_sa ^ w_sb;
                            w_neg_rem_nxt = w_sa;
                            w_b_nxt       = w_is_div ? w_mag_b : w_mag_a;
                            w_acc_nxt     = {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            w_count_nxt   = '0;
                            w_state_nxt   = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    w_acc_nxt   = w_step;
                    w_count_nxt = r_count + CW'(1);
                    if (r_count == CW'(XLEN - 1)) begin
                        w_result_nxt = w_final;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_op      <= w_op_nxt;
            r_neg     <= w_neg_nxt;
            r_neg_rem <= w_neg_rem_nxt;
            r_b       <= w_b_nxt;
            r_acc     <= w_acc_nxt;
            r_result  <= w_result_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.E_md_busy_o   = w_start || (r_state == S_CALC);
    assign bus.E_md_done_o   = r_done;
    assign bus.E_md_result_o = r_result;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: results, latency, busy/done timing, kill and reset abort.
module tb_execute_muldiv;
    localparam int unsigned XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_muldiv_if #(.XLEN(XLEN)) bus();
    execute_muldiv #(.XLEN(XLEN)) u_dut (.clk_i(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered between edges; checks result, done cycle, busy profile and single-cycle done
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat = 0;
        int busy_cyc = 0;
        logic [31:0] res = '0;
        logic busy_at_done = 1'b1;
        bus.E_md_op_i    = op;
        bus.E_rs1_data_i = a;
        bus.E_rs2_data_i = b;
        bus.E_md_valid_i = 1'b1;
        #1;
        check_eq({tag, "/busy0"}, 32'(bus.E_md_busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.E_md_valid_i = 1'b0;
        bus.E_rs1_data_i = $urandom;
        bus.E_rs2_data_i = $urandom;
        bus.E_md_op_i    = 3'($urandom);
        #1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.E_md_done_o) begin
                lat = c;
                res = bus.E_md_result_o;
                busy_at_done = bus.E_md_busy_o;
                break;
            end
            if (bus.E_md_busy_o) busy_cyc++;
            @(posedge clk);
            #2;
        end
        check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "/result"}, res, exp_res);
        check_eq({tag, "/busy_in_done"}, 32'(busy_at_done), 32'd0);
        check_eq({tag, "/busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
        @(posedge clk);
        #2;
        check_eq({tag, "/done_pulse"}, 32'(bus.E_md_done_o), 32'd0);
    endtask

    // Starts a MUL and aborts it at cycle 10 by kill or by reset
    task automatic run_abort(input string tag, input bit use_rst, input logic [31:0] exp_res);
        int n_done = 0;
        bus.E_md_op_i    = 3'd0;
        bus.E_rs1_data_i = 32'd7;
        bus.E_rs2_data_i = 32'hFFFF_FFFD;
        bus.E_md_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.E_md_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         bus.E_md_kill_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.E_md_kill_i = 1'b0;
        #1;
        check_eq({tag, "/busy_after"}, 32'(bus.E_md_busy_o), 32'd0);
        check_eq({tag, "/done_after"}, 32'(bus.E_md_done_o), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.E_md_done_o) n_done++;
            @(posedge clk);
            #2;
        end
        check_eq({tag, "/no_done"}, 32'(n_done), 32'd0);
        check_eq({tag, "/result_kept"}, bus.E_md_result_o, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.E_md_valid_i = 1'b0;
        bus.E_md_kill_i  = 1'b0;
        bus.E_md_op_i    = 3'd0;
        bus.E_rs1_data_i = '0;
        bus.E_rs2_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("reset/result", bus.E_md_result_o, 32'd0);
        check_eq("reset/done", 32'(bus.E_md_done_o), 32'd0);
        check_eq("reset/busy", 32'(bus.E_md_busy_o), 32'd0);

        run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mul_big",      3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
        run_op("mulhu_m1_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_m1_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,        33);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,         33);
        run_op("divu_5_0",     3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_5_0",      3'd6, 32'd5,        32'd0,        32'd5,         1);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("divu_3_10",    3'd5, 32'd3,        32'd10,       32'd0,         EARLY_LAT);
        run_op("rem_m3_10",    3'd6, 32'hFFFF_FFFD, 32'd10,       32'hFFFF_FFFD, EARLY_LAT);
        run_op("remu_3_10",    3'd7, 32'd3,        32'd10,       32'd3,         EARLY_LAT);

        run_abort("kill", 1'b0, 32'd3);
        run_op("mul_after_kill", 3'd0, 32'd6, 32'd9, 32'd54, 33);
        run_abort("reset", 1'b1, 32'd0);
        run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Iterative RV32M multiply/divide unit inside the execute stage, directly downstream of the decode/execute pipeline register.
- Consumes the registered operands and op (DD_rs1_data, DD_rs2_data, M-extension funct3) when the instruction is an M-type op.
- Computes the result over multiple cycles and raises a busy/stall request to the hazard unit. That request holds the decode/execute register (D_stall) and upstream stages until the result is ready.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- E_md_valid_i  in  1  an M-type instruction is present in execute; operands and op are valid
- E_md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- E_rs1_data_i  in  XLEN  operand A (rs1)
- E_rs2_data_i  in  XLEN  operand B (rs2)
- E_md_kill_i  in  1  flush of the execute instruction; aborts any operation in flight
- E_md_busy_o  out  1  stall request to the hazard unit
- E_md_done_o  out  1  one-cycle pulse; E_md_result_o is valid this cycle
- E_md_result_o  out  XLEN  result, held until the next operation completes

Behaviour:
- Reset: async, active-high. state=IDLE, count=0, internal accumulators=0, E_md_result_o=0, E_md_done_o=0.
- States and transitions:
  - IDLE. If E_md_valid_i & ~E_md_kill_i at the edge:
    - special case (below): go to DONE with the result preloaded;
    - otherwise: latch operand magnitudes, sign flags and op; count=0; go to CALC.
  - CALC. One radix-2 step per cycle, count++. After step XLEN-1 (count==XLEN-1), compute the final result with sign fix-up, register it, go to DONE.
  - DONE. E_md_done_o=1, E_md_result_o valid. Next state is IDLE unconditionally. E_md_valid_i is ignored here, so the same instruction never restarts.
- E_md_busy_o is combinational: (state==IDLE & E_md_valid_i & ~E_md_kill_i) | state==CALC. It is low in DONE, so the instruction advances at the end of the DONE cycle.
- Latency, with valid seen at edge 0:
  - normal op: done at cycle XLEN+1 (33 for XLEN=32);
  - special case: done at cycle 1.
- Multiply: unsigned shift-add on magnitudes into a 2*XLEN product.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; MULHU treats both unsigned.
  - Sign fix-up: negate the product if the effective signs differ.
  - Output: MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide: restoring division on magnitudes.
  - Signedness: DIV/REM are signed, DIVU/REMU unsigned.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Special cases (no CALC):
  - divisor==0: quotient=all ones, remainder=rs1.
  - signed overflow (rs1=100..0, rs2=all ones, DIV/REM): quotient=rs1, remainder=0.
- Kill: highest priority below reset. In any state, next state=IDLE and no done pulse. E_md_result_o keeps its previous value.
- Operand inputs may change after acceptance; the unit uses only its latched copies.
- Reset asserted mid-CALC: immediate return to IDLE; no done pulse after deassertion.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: a DIV/DIVU/REM/REMU with nonzero divisor and |rs1| < |rs2| (magnitudes) is treated as a special case: quotient=0, remainder=rs1. It goes IDLE->DONE with done at cycle 1.
- Undefined: such ops take the full XLEN-step path, done at cycle XLEN+1. Results are identical either way.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> busy high cycles 0..32; done pulse at cycle 33; result 0xFFFFFFEB; busy low in DONE.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done at cycle 1. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done at cycle 1. REM with the same operands -> 0.
- Start MUL, assert E_md_kill_i at cycle 10 -> IDLE next cycle, no done pulse, result unchanged. Repeat using rst at cycle 10 -> same outcome and result=0.
- DIVU 3/10 -> quotient 0, done at cycle 1 with DIV_EARLY_OUT_EN defined; done at cycle 33 without it.
